// File: rtl/pkt_rr_scheduler.sv
// rtl/pkt_rr_scheduler.sv - five-port round-robin packet scheduler with single multicast copy
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid, in_ready    per-port request / registered accept (0 up, 1 down, 2 left, 3 right, 4 local)
//   in_data               port i occupies [i*WIDTH_PKT +: WIDTH_PKT]
//   out_valid, out_ready  output handshake (out_valid registered)
//   out_data, out_src     output packet and granted port index
//   out_is_copy           out_data is a generated copy
//   busy                  FSM not idle or any slot holds a packet
module pkt_rr_scheduler #(
   parameter int         WIDTH_PKT = 32,
   parameter logic [2:0] ADDRX     = 3'd0,
   parameter logic [4:0] ADDRY     = 5'd0,
   parameter int         DEPTH_R   = 21,
   parameter int         DEPTH_F   = 5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4:0]             in_valid,
   output logic [4:0]             in_ready,
   input  logic [5*WIDTH_PKT-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH_PKT-1:0]   out_data,
   output logic [2:0]             out_src,
   output logic                   out_is_copy,
   output logic                   busy
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_COPY} state_t;

   // Copy eligibility depends only on where this node sits in the mesh.
   localparam logic [4:0] LAST_Y  = 5'(DEPTH_R - 1);
   localparam logic [2:0] LAST_X  = 3'(DEPTH_F - 1);
   localparam bit         FILT_OK = (ADDRY != LAST_Y);
   localparam bit         IFM_OK  = (ADDRY != 5'd0) && (ADDRX != LAST_X);

   state_t               state_q, state_d;
   logic [2:0]           ptr_q, ptr_d;
   logic [4:0]           slot_full_q, slot_full_d, slot_clr;
   logic [WIDTH_PKT-1:0] slot_data_q [5];
   logic [4:0]           in_ready_q;
   logic                 out_valid_q, out_valid_d;
   logic [WIDTH_PKT-1:0] out_data_q, out_data_d;
   logic [2:0]           out_src_q, out_src_d;
   logic                 out_is_copy_q, out_is_copy_d;
   logic [4:0]           accept;
   logic [2:0]           grant_idx;
   logic                 dst_here, need_filt, need_ifm;
   logic [WIDTH_PKT-1:0] copy_pkt;

   function automatic logic [2:0] rr_idx(input logic [2:0] base, input logic [2:0] off);
      logic [3:0] s;
      s = {1'b0, base} + {1'b0, off};
      if (s >= 4'd5) s = s - 4'd5;
      return s[2:0];
   endfunction

   assign accept = in_valid & in_ready_q;

   // Descending scan so the lowest offset from ptr wins.
   always_comb begin
      grant_idx = ptr_q;
      for (int k = 4; k >= 0; k--) begin
         if (slot_full_q[rr_idx(ptr_q, 3'(k))]) grant_idx = rr_idx(ptr_q, 3'(k));
      end
   end

   // Copy decision is taken from the original packet held in out_data_q during SEND.
   assign dst_here  = (out_data_q[28:21] == {ADDRY, ADDRX});
   assign need_filt = FILT_OK && (out_data_q[30:29] == 2'b00) && dst_here;
   assign need_ifm  = IFM_OK  && (out_data_q[30:29] == 2'b01) && dst_here;

   always_comb begin
      copy_pkt = out_data_q;
      if (need_filt) copy_pkt[28:24] = ADDRY + 5'd1;
      if (need_ifm) begin
         copy_pkt[28:24] = ADDRY - 5'd1;
         copy_pkt[23:21] = ADDRX + 3'd1;
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_src_d     = out_src_q;
      out_is_copy_d = out_is_copy_q;
      slot_clr      = 5'b0;
      case (state_q)
         S_IDLE: begin
            if (|slot_full_q) begin
               out_data_d    = slot_data_q[grant_idx];
               out_src_d     = grant_idx;
               out_is_copy_d = 1'b0;
               out_valid_d   = 1'b1;
               state_d       = S_SEND;
            end else begin
               out_valid_d = 1'b0;
            end
         end
         S_SEND: begin
            if (out_ready) begin
               if (need_filt || need_ifm) begin
                  out_data_d    = copy_pkt;
                  out_is_copy_d = 1'b1;
                  state_d       = S_COPY;
               end else begin
                  slot_clr    = 5'b1 << out_src_q;
                  ptr_d       = rr_idx(out_src_q, 3'd1);
                  out_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end
            end
         end
         S_COPY: begin
            if (out_ready) begin
               slot_clr    = 5'b1 << out_src_q;
               ptr_d       = rr_idx(out_src_q, 3'd1);
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
      slot_full_d = (slot_full_q & ~slot_clr) | accept;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         ptr_q         <= 3'd0;
         slot_full_q   <= 5'b0;
         in_ready_q    <= 5'b0;
         out_valid_q   <= 1'b0;
         out_data_q    <= '0;
         out_src_q     <= 3'd0;
         out_is_copy_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         slot_full_q   <= slot_full_d;
         // Based on next-state fullness so a slot never accepts twice.
         in_ready_q    <= ~slot_full_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_src_q     <= out_src_d;
         out_is_copy_q <= out_is_copy_d;
      end
   end

   // Slot payload is qualified by slot_full_q, so it needs no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 5; i++) begin
         if (accept[i]) slot_data_q[i] <= in_data[i*WIDTH_PKT +: WIDTH_PKT];
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_src     = out_src_q;
   assign out_is_copy = out_is_copy_q;
   assign busy        = (state_q != S_IDLE) || (|slot_full_q);

endmodule

// File: doc/pkt_rr_scheduler.md
PKT_RR_SCHEDULER -- requirements
Module: pkt_rr_scheduler

Interface
REQ-001 SHALL have parameter WIDTH_PKT, default 32: packet width; type field is [30:29], destination is [28:21] = {Y[4:0], X[2:0]}.
REQ-002 SHALL have parameters ADDRX, default 3'd0, and ADDRY, default 5'd0: this node's X and Y address.
REQ-003 SHALL have parameters DEPTH_R, default 21, and DEPTH_F, default 5: mesh row and column extents used by the copy rules.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid  input  5: per-port request; index 0=up, 1=down, 2=left, 3=right, 4=local.
REQ-007 SHALL have port in_ready  output  5: per-port accept, registered.
REQ-008 SHALL have port in_data  input  5*WIDTH_PKT: port i occupies bits [i*WIDTH_PKT +: WIDTH_PKT].
REQ-009 SHALL have port out_valid  output  1: output packet valid, registered.
REQ-010 SHALL have port out_ready  input  1: downstream accept.
REQ-011 SHALL have port out_data  output  WIDTH_PKT: output packet, registered.
REQ-012 SHALL have port out_src  output  3: granted port index for the current output.
REQ-013 SHALL have port out_is_copy  output  1: high when out_data is a generated copy.
REQ-014 SHALL have port busy  output  1: high when the FSM is not IDLE or any slot is full.

Function
REQ-015 SHALL give each port a one-entry slot; input accept is in_valid[i] & in_ready[i], and it captures in_data[i] and sets slot_full[i] on the next edge.
REQ-016 SHALL drive in_ready[i] as the registered value of ~slot_full[i]; in_ready[i] drops the cycle after accept and rises the cycle after slot clear.
REQ-017 SHALL run an FSM with states IDLE, SEND and COPY, plus a round-robin pointer ptr in 0..4.
REQ-018 In IDLE with any slot full, SHALL grant the first full slot scanning ptr, ptr+1, ... (mod 5), load out_data, out_src and out_is_copy=0, set out_valid, and go to SEND.
REQ-019 In IDLE with no slot full, SHALL hold out_valid=0 and stay in IDLE.
REQ-020 SHALL allow a minimum latency of 2 cycles from input accept to out_valid.
REQ-021 While out_valid=1 and out_ready=0, SHALL hold out_data, out_src and out_is_copy stable.
REQ-022 On a SEND handshake with a copy required (REQ-024/025), SHALL load the copy packet, set out_is_copy=1, keep out_valid=1, and go to COPY; there is no bubble.
REQ-023 On a SEND handshake with no copy required, or on a COPY handshake, SHALL clear the granted slot, set ptr=(grant+1) mod 5, drop out_valid, and go to IDLE.
REQ-024 Filter copy: if type==2'b00, dst=={ADDRY,ADDRX} and ADDRY!=DEPTH_R-1, the copy SHALL have dst Y=ADDRY+1, same X, and all other bits unchanged.
REQ-025 Ifmap copy: if type==2'b01, dst=={ADDRY,ADDRX}, ADDRY!=0 and ADDRX!=DEPTH_F-1, the copy SHALL have X=ADDRX+1, Y=ADDRY-1, and all other bits unchanged.
REQ-026 SHALL produce at most one copy per packet; other types (2'b10, 2'b11) never produce a copy.
REQ-027 SHALL not clear a granted slot before its final handshake; at most one slot is granted at a time.
REQ-028 SHALL let non-granted slots accept new packets during SEND and COPY.
REQ-029 SHALL wrap ptr from 4 to 0; ptr changes only per REQ-023.

Reset
REQ-030 While rst_n=0 at a clock edge, SHALL force state=IDLE, ptr=0, slot_full=0, in_ready=0, out_valid=0, out_data=0, out_src=0 and out_is_copy=0.
REQ-031 SHALL raise in_ready to 5'b11111 on the first edge with rst_n=1.
REQ-032 Reset mid-operation SHALL drop all pending packets and any in-flight copy; no output follows it.

Verification (ADDRX=2, ADDRY=13)
REQ-033 Single-packet scenario: local sends {3'b011, 5'd4, 3'd1, 21'd5} with out_ready=1 -> one output 2 cycles later, out_src=4, out_is_copy=0, then busy=0.
REQ-034 Round-robin scenario: all 5 ports valid simultaneously with non-copy packets and out_ready=1 -> output order 0,1,2,3,4; port 0 refills -> port 0 is granted again only after port 4.
REQ-035 Filter-copy scenario: up sends type 00 with dst {13,2} -> outputs are the original, then a copy with dst {14,2} and out_is_copy=1 in the next cycle; no copy is produced when ADDRY=20.
REQ-036 Ifmap-copy scenario: type 01 with dst {13,2} -> copy dst {12,3}; no copy is produced when ADDRX=4 or ADDRY=0.
REQ-037 Backpressure scenario: out_ready=0 for 10 cycles during SEND -> out_data stable, in_ready[grant]=0, other ports still accept; release -> send completes.
REQ-038 Mid-copy reset scenario: assert rst_n=0 in COPY -> next cycle out_valid=0 and slot_full=0; after release, in_ready=5'b11111.
